// File: rtl/hpgp_itl_pkg.sv
// Shared constants, FSM state encoding and the row/column interleave map
// for the HPGP interleaver frame buffer.
package hpgp_itl_pkg;

    localparam int unsigned DEF_DEPTH = 256;
    localparam int unsigned DEF_ROWS  = 16;
    localparam int unsigned DEF_COLS  = 16;
    localparam int unsigned DEF_ID_W  = 6;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WR    = 2'd1;
    localparam state_t ST_READY = 2'd2;

    // k = c*rows + r  ->  ((r + off) mod rows) * cols + c
    function automatic int unsigned itl_addr(input int unsigned k,
                                             input int unsigned off,
                                             input int unsigned rows = DEF_ROWS,
                                             input int unsigned cols = DEF_COLS);
        int unsigned r;
        int unsigned c;
        r = k % rows;
        c = k / rows;
        return (((r + off) % rows) * cols) + c;
    endfunction

endpackage

// File: rtl/hpgp_itl_addr_gen.sv
// Combinational read-index to interleaved-address translation.
module hpgp_itl_addr_gen
    import hpgp_itl_pkg::*;
#(
    parameter  int unsigned DEPTH = DEF_DEPTH,
    parameter  int unsigned ROWS  = DEF_ROWS,
    parameter  int unsigned COLS  = DEF_COLS,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned RW    = $clog2(ROWS)
) (
    input  logic [AW-1:0] k,
    input  logic [RW-1:0] off,
    output logic [AW-1:0] addr_c
);

    assign addr_c = AW'(itl_addr(32'(k), 32'(off), ROWS, COLS));

endmodule

// File: rtl/hpgp_itl_frame_buffer.sv
// Single-frame bit buffer with natural and block-interleaved readout.
// Optional sticky protocol-error output enabled by defining HPGP_ITL_ERR_EN.
module hpgp_itl_frame_buffer
    import hpgp_itl_pkg::*;
#(
    parameter  int unsigned DEPTH = DEF_DEPTH,
    parameter  int unsigned ROWS  = DEF_ROWS,
    parameter  int unsigned COLS  = DEF_COLS,
    parameter  int unsigned ID_W  = DEF_ID_W,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned RW    = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [ID_W-1:0] link_id,
    input  logic            din,
    input  logic            din_vld,
    input  logic            request,
    output logic            rdata,
    output logic            rdata_itl,
    output logic            rvld,
    output logic            ready,
    output logic            done
`ifdef HPGP_ITL_ERR_EN
    ,
    output logic            err
`endif
);

    state_t        state, state_nx;
    logic [AW-1:0] wptr, wptr_nx;
    logic [AW-1:0] rptr, rptr_nx;
    logic [RW-1:0] off, off_nx;
    logic          we_c, rd_c, last_rd_c;
    logic [AW-1:0] itl_addr_c;
    logic          mem [DEPTH];

    hpgp_itl_addr_gen #(
        .DEPTH (DEPTH),
        .ROWS  (ROWS),
        .COLS  (COLS)
    ) u_addr_gen (
        .k      (rptr),
        .off    (off),
        .addr_c (itl_addr_c)
    );

    // Next-state and pointer logic; wptr is always 0 while idle
    always_comb begin
        state_nx  = state;
        wptr_nx   = wptr;
        rptr_nx   = rptr;
        off_nx    = off;
        we_c      = 1'b0;
        rd_c      = 1'b0;
        last_rd_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (din_vld) begin
                    we_c     = 1'b1;
                    off_nx   = RW'(link_id);
                    wptr_nx  = AW'(1);
                    state_nx = ST_WR;
                end
            end
            ST_WR: begin
                we_c = 1'b1;
                if (wptr == AW'(DEPTH - 1)) begin
                    wptr_nx  = '0;
                    state_nx = ST_READY;
                end else begin
                    wptr_nx = wptr + AW'(1);
                end
            end
            ST_READY: begin
                if (request) begin
                    rd_c = 1'b1;
                    if (rptr == AW'(DEPTH - 1)) begin
                        last_rd_c = 1'b1;
                        rptr_nx   = '0;
                        state_nx  = ST_IDLE;
                    end else begin
                        rptr_nx = rptr + AW'(1);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= ST_IDLE;
            wptr  <= '0;
            rptr  <= '0;
            off   <= '0;
        end else begin
            state <= state_nx;
            wptr  <= wptr_nx;
            rptr  <= rptr_nx;
            off   <= off_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rvld      <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b0;
            rdata     <= 1'b0;
            rdata_itl <= 1'b0;
        end else begin
            rvld  <= rd_c;
            done  <= last_rd_c;
            ready <= (state_nx == ST_READY);
            if (rd_c) begin
                rdata     <= mem[rptr];
                rdata_itl <= mem[itl_addr_c];
            end
        end
    end

    // Storage is intentionally not cleared by reset
    always_ff @(posedge clk) begin
        if (n_rst && we_c) begin
            mem[wptr] <= din;
        end
    end

`ifdef HPGP_ITL_ERR_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            err <= 1'b0;
        end else if ((din_vld && (state != ST_IDLE)) || (request && (state != ST_READY))) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
